// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and codes for the sequential Karatsuba multiplier
package mult_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_Z0, S_Z2, S_SA, S_SB, S_Z1M, S_S0, S_S2, S_C1, S_C2, S_DONE
  } state_t;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  typedef enum logic [1:0] {
    MUL_LL, MUL_HH, MUL_SS
  } mul_sel_t;

  typedef enum logic [2:0] {
    AS_AHAL, AS_BHBL, AS_MZ0, AS_Z1Z2, AS_C1, AS_C2
  } as_sel_t;

endpackage

// File: rtl/mult_addsub.sv
// rtl/mult_addsub.sv - shared (H+1)x(H+1) multiplier and 2*WIDTH add/sub with operand muxes
module mult_addsub
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mul_sel_t                 mul_sel,
  input  as_sel_t                  as_sel,
  input  logic                     as_op,
  input  logic [WIDTH-1:0]         a_r,
  input  logic [WIDTH-1:0]         b_r,
  input  logic [WIDTH/2:0]         sa,
  input  logic [WIDTH/2:0]         sb,
  input  logic [WIDTH-1:0]         z0,
  input  logic [WIDTH-1:0]         z2,
  input  logic [WIDTH+1:0]         m,
  input  logic [WIDTH:0]           z1,
  input  logic [2*WIDTH-1:0]       acc,
  output logic [WIDTH+1:0]         mul_out,
  output logic [2*WIDTH-1:0]       as_out
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  logic [H:0]    mul_x, mul_y;
  logic [PW-1:0] as_x, as_y;

  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (mul_sel)
      MUL_LL: begin
        mul_x = {1'b0, a_r[H-1:0]};
        mul_y = {1'b0, b_r[H-1:0]};
      end
      MUL_HH: begin
        mul_x = {1'b0, a_r[WIDTH-1:H]};
        mul_y = {1'b0, b_r[WIDTH-1:H]};
      end
      MUL_SS: begin
        mul_x = sa;
        mul_y = sb;
      end
      default: ;
    endcase
  end

  assign mul_out = mul_x * mul_y;

  // Every operand is zero-extended to the full product width before the add/sub
  always_comb begin
    as_x = '0;
    as_y = '0;
    case (as_sel)
      AS_AHAL: begin
        as_x = {{(PW-H){1'b0}}, a_r[WIDTH-1:H]};
        as_y = {{(PW-H){1'b0}}, a_r[H-1:0]};
      end
      AS_BHBL: begin
        as_x = {{(PW-H){1'b0}}, b_r[WIDTH-1:H]};
        as_y = {{(PW-H){1'b0}}, b_r[H-1:0]};
      end
      AS_MZ0: begin
        as_x = {{(PW-WIDTH-2){1'b0}}, m};
        as_y = {{(PW-WIDTH){1'b0}}, z0};
      end
      AS_Z1Z2: begin
        as_x = {{(PW-WIDTH-1){1'b0}}, z1};
        as_y = {{(PW-WIDTH){1'b0}}, z2};
      end
      AS_C1: begin
        as_x = {{(PW-WIDTH){1'b0}}, z0};
        as_y = {{(PW-WIDTH-1-H){1'b0}}, z1, {H{1'b0}}};
      end
      AS_C2: begin
        as_x = acc;
        as_y = {z2, {WIDTH{1'b0}}};
      end
      default: ;
    endcase
  end

  assign as_out = (as_op == OP_ADD) ? (as_x + as_y) : (as_x - as_y);

endmodule

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - multi-cycle unsigned multiplier, one-level Karatsuba over shared arithmetic
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int H = WIDTH / 2;

  state_t   state, state_nxt;
  mul_sel_t mul_sel;
  as_sel_t  as_sel;
  logic     as_op;

  logic [WIDTH-1:0]   a_r, b_r;
  logic [2*H-1:0]     z0, z2;
  logic [H:0]         sa, sb;
  logic [2*H+1:0]     m, mul_out;
  logic [2*H:0]       z1;
  logic [2*WIDTH-1:0] acc, as_out;

  mult_addsub #(.WIDTH(WIDTH)) u_arith (
    .mul_sel (mul_sel),
    .as_sel  (as_sel),
    .as_op   (as_op),
    .a_r     (a_r),
    .b_r     (b_r),
    .sa      (sa),
    .sb      (sb),
    .z0      (z0),
    .z2      (z2),
    .m       (m),
    .z1      (z1),
    .acc     (acc),
    .mul_out (mul_out),
    .as_out  (as_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    mul_sel   = MUL_LL;
    as_sel    = AS_AHAL;
    as_op     = OP_ADD;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_CLR;
      end
      S_CLR:  state_nxt = S_Z0;
      S_Z0:  begin mul_sel = MUL_LL; state_nxt = S_Z2; end
      S_Z2:  begin mul_sel = MUL_HH; state_nxt = S_SA; end
      S_SA:  begin as_sel = AS_AHAL; as_op = OP_ADD; state_nxt = S_SB; end
      S_SB:  begin as_sel = AS_BHBL; as_op = OP_ADD; state_nxt = S_Z1M; end
      S_Z1M: begin mul_sel = MUL_SS; state_nxt = S_S0; end
      S_S0:  begin as_sel = AS_MZ0;  as_op = OP_SUB; state_nxt = S_S2; end
      S_S2:  begin as_sel = AS_Z1Z2; as_op = OP_SUB; state_nxt = S_C1; end
      S_C1:  begin as_sel = AS_C1;   as_op = OP_ADD; state_nxt = S_C2; end
      S_C2:  begin as_sel = AS_C2;   as_op = OP_ADD; state_nxt = S_DONE; end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // S_CLR wipes the previous operation's intermediates before the new one starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      z0      <= '0;
      z2      <= '0;
      sa      <= '0;
      sb      <= '0;
      m       <= '0;
      z1      <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_r <= a;
          b_r <= b;
        end
        S_CLR: begin
          z0  <= '0;
          z2  <= '0;
          sa  <= '0;
          sb  <= '0;
          m   <= '0;
          z1  <= '0;
          acc <= '0;
        end
        S_Z0:  z0 <= mul_out[2*H-1:0];
        S_Z2:  z2 <= mul_out[2*H-1:0];
        S_SA:  sa <= as_out[H:0];
        S_SB:  sb <= as_out[H:0];
        S_Z1M: m  <= mul_out;
        S_S0:  z1 <= as_out[2*H:0];
        S_S2:  z1 <= as_out[2*H:0];
        S_C1:  acc <= as_out;
        S_C2: begin
          acc     <= as_out;
          product <= as_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - self-checking bench for mult_seq at WIDTH=8 and WIDTH=16
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, busy16, done16;
  logic [15:0] product8;
  logic [31:0] product16;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(product16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start pulse from IDLE, returns cycles to done and the product; ends back in IDLE
  task automatic run_op(input bit wide, input logic [15:0] x, input logic [15:0] y,
                        output int lat, output logic [31:0] prod);
    if (wide) begin a16 = x; b16 = y; start16 = 1'b1; end
    else begin a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1; end
    tick();
    start8  = 1'b0;
    start16 = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(wide ? done16 : done8) && lat < 40);
    prod = wide ? product16 : {16'h0, product8};
    tick();
  endtask

  initial begin
    int          lat, ndone, dc, stable_err;
    logic [31:0] prod, last_p;
    logic [15:0] x, y;
    int          dt[3];
    logic [7:0]  pa[3], pb[3];

    tbl[0] = '{8'h12, 8'h34, 16'h03A8};
    tbl[1] = '{8'hFF, 8'hFF, 16'hFE01};
    tbl[2] = '{8'h00, 8'hAB, 16'h0000};
    tbl[3] = '{8'h0F, 8'h0F, 16'h00E1};
    tbl[4] = '{8'h80, 8'h02, 16'h0100};
    tbl[5] = '{8'h01, 8'hFF, 16'h00FF};

    rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_busy8", busy8, 0);
    check("reset_done8", done8, 0);
    check("reset_product8", product8, 0);
    check("reset_busy16", busy16, 0);
    check("reset_product16", product16, 0);

    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, {8'h0, tbl[i].a}, {8'h0, tbl[i].b}, lat, prod);
      check("table_latency", lat, 10);
      check("table_product", prod, {16'h0, tbl[i].p});
      check("table_idle_after", busy8, 0);
    end

    // Restart attempt while busy must be ignored
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    ndone = 0; dc = 0; last_p = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start8 = (c == 3);
      if (c == 3) begin a8 = 8'h55; b8 = 8'h66; end
      if (done8) begin ndone++; dc = c; last_p = {16'h0, product8}; end
    end
    start8 = 1'b0;
    check("ignore_done_count", ndone, 1);
    check("ignore_done_cycle", dc, 10);
    check("ignore_product", last_p, 32'h03A8);
    check("ignore_idle", busy8, 0);

    // Asynchronous abort in the middle of an operation
    a8 = 8'hAB; b8 = 8'hCD; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    ndone = 0;
    repeat (5) begin tick(); if (done8) ndone++; end
    rst = 1'b1;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_product", product8, 0);
    repeat (2) begin tick(); if (done8) ndone++; end
    rst = 1'b0;
    repeat (12) begin tick(); if (done8) ndone++; end
    check("abort_no_done", ndone, 0);
    run_op(1'b0, 16'h000F, 16'h000F, lat, prod);
    check("after_abort_latency", lat, 10);
    check("after_abort_product", prod, 32'h00E1);

    // start held high: back-to-back operations every 12 cycles
    pa[0] = 8'h12; pb[0] = 8'h34;
    pa[1] = 8'hFF; pb[1] = 8'hFF;
    pa[2] = 8'h3C; pb[2] = 8'hA5;
    a8 = pa[0]; b8 = pb[0]; start8 = 1'b1;
    ndone = 0; stable_err = 0; last_p = '0;
    dt[0] = 0; dt[1] = 0; dt[2] = 0;
    for (int c = 1; c <= 60 && ndone < 3; c++) begin
      tick();
      if (done8) begin
        dt[ndone] = c;
        check("held_product", product8, 16'(pa[ndone] * pb[ndone]));
        last_p = {16'h0, product8};
        ndone++;
        if (ndone < 3) begin a8 = pa[ndone]; b8 = pb[ndone]; end
        else start8 = 1'b0;
      end else if (ndone > 0 && {16'h0, product8} !== last_p) begin
        stable_err++;
      end
    end
    start8 = 1'b0;
    check("held_done_count", ndone, 3);
    check("held_first_done", dt[0], 11);
    check("held_spacing1", dt[1] - dt[0], 12);
    check("held_spacing2", dt[2] - dt[1], 12);
    check("held_product_stable", stable_err, 0);
    repeat (2) tick();
    check("held_idle", busy8, 0);

    run_op(1'b1, 16'hFFFF, 16'hFFFF, lat, prod);
    check("w16_corner_latency", lat, 10);
    check("w16_corner_product", prod, 32'hFFFE0001);
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      run_op(1'b1, x, y, lat, prod);
      check("w16_random", prod, 32'(x) * 32'(y));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
